// File: rtl/axis_fifo_sync_if.sv
// rtl/axis_fifo_sync_if.sv - AXI-stream beat bundle with master/slave modports
interface axis_fifo_sync_if #(
  parameter int DATA_WIDTH = 72
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_fifo_sync.sv
// rtl/axis_fifo_sync.sv - single-clock AXI-stream FIFO with registered output stage
// Optional level counter: define AXIS_FIFO_SYNC_LEVEL_EN; otherwise fifo_level is tied to 0.
module axis_fifo_sync #(
  parameter int DATA_WIDTH = 72,
  parameter int FIFO_DEPTH = 16,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    axis_clk,
  input  logic                    axis_rst,
  axis_fifo_sync_if.slave         s_axis,
  axis_fifo_sync_if.master        m_axis,
  output logic [LW-1:0]           fifo_level
);
  localparam int AW = LW - 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [LW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         ld_ptr_q, ld_ptr_d;
  logic                  s_ready_q, s_ready_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  wr_en, rd_en, ld_en;

  // ld_ptr marks the oldest stored beat not yet copied into the output register;
  // comparing against the registered wr_ptr only sees beats written in earlier cycles.
  always_comb begin
    wr_en     = s_axis.tvalid & s_ready_q;
    rd_en     = m_valid_q & m_axis.tready;
    ld_en     = (~m_valid_q | rd_en) & (ld_ptr_q != wr_ptr_q);
    wr_ptr_d  = wr_ptr_q + LW'(wr_en);
    rd_ptr_d  = rd_ptr_q + LW'(rd_en);
    ld_ptr_d  = ld_ptr_q + LW'(ld_en);
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    if (ld_en) begin
      m_valid_d = 1'b1;
      m_data_d  = mem[ld_ptr_q[AW-1:0]];
    end else if (rd_en) begin
      m_valid_d = 1'b0;
    end
    s_ready_d = (wr_ptr_d ^ rd_ptr_d) != {1'b1, {AW{1'b0}}};
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ld_ptr_q  <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ld_ptr_q  <= ld_ptr_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (wr_en && !axis_rst) begin
      mem[wr_ptr_q[AW-1:0]] <= s_axis.tdata;
    end
  end

  assign s_axis.tready = s_ready_q;
  assign m_axis.tvalid = m_valid_q;
  assign m_axis.tdata  = m_data_q;

`ifdef AXIS_FIFO_SYNC_LEVEL_EN
  logic [LW-1:0] level_q;

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      level_q <= '0;
    end else if (wr_en && !rd_en) begin
      level_q <= level_q + LW'(1);
    end else if (rd_en && !wr_en) begin
      level_q <= level_q - LW'(1);
    end
  end

  assign fifo_level = level_q;
`else
  assign fifo_level = '0;
`endif

endmodule

// File: tb/tb_axis_fifo_sync.sv
// tb/tb_axis_fifo_sync.sv - directed self-checking bench for axis_fifo_sync
module tb_axis_fifo_sync;
  localparam int DW = 72;
  localparam int DEPTH = 16;
  localparam int LW = 5;

  logic          axis_clk = 1'b0;
  logic          axis_rst = 1'b1;
  logic [LW-1:0] fifo_level;
  int            n_pass = 0;
  int            n_total = 0;

  axis_fifo_sync_if #(.DATA_WIDTH(DW)) s_if ();
  axis_fifo_sync_if #(.DATA_WIDTH(DW)) m_if ();

  axis_fifo_sync #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .axis_clk   (axis_clk),
    .axis_rst   (axis_rst),
    .s_axis     (s_if),
    .m_axis     (m_if),
    .fifo_level (fifo_level)
  );

  always #5 axis_clk = ~axis_clk;

  function automatic logic [LW-1:0] lv(input int n);
`ifdef AXIS_FIFO_SYNC_LEVEL_EN
    return LW'(n);
`else
    return '0;
`endif
  endfunction

  function automatic logic [DW-1:0] pat(input int i);
    return {8'hA5, 32'(i * 7 + 3), 32'(~i)};
  endfunction

  task automatic tick();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic test_reset();
    axis_rst = 1'b1;
    s_if.tvalid = 1'b0;
    s_if.tdata = '0;
    m_if.tready = 1'b0;
    tick(); tick(); tick();
    n_total++;
    if (s_if.tready !== 1'b0) $display("FAIL rst_tready_during: got %0b want 0", s_if.tready);
    else n_pass++;
    axis_rst = 1'b0;
    tick();
    n_total++;
    if (s_if.tready !== 1'b1) $display("FAIL rst_tready_after: got %0b want 1", s_if.tready);
    else n_pass++;
    n_total++;
    if (m_if.tvalid !== 1'b0 || m_if.tdata !== '0 || fifo_level !== lv(0))
      $display("FAIL rst_outputs: tvalid=%0b tdata=%h level=%0d want 0/0/%0d",
               m_if.tvalid, m_if.tdata, fifo_level, lv(0));
    else n_pass++;
  endtask

  task automatic test_single_beat();
    logic [DW-1:0] d;
    d = 72'h0123456789ABCDEF01;
    s_if.tvalid = 1'b1;
    s_if.tdata = d;
    m_if.tready = 1'b1;
    n_total++;
    if (s_if.tready !== 1'b1) $display("FAIL single_ready: got %0b want 1", s_if.tready);
    else n_pass++;
    tick();
    s_if.tvalid = 1'b0;
    n_total++;
    if (m_if.tvalid !== 1'b0 || fifo_level !== lv(1))
      $display("FAIL single_c1: tvalid=%0b level=%0d want 0/%0d", m_if.tvalid, fifo_level, lv(1));
    else n_pass++;
    tick();
    n_total++;
    if (m_if.tvalid !== 1'b1 || m_if.tdata !== d || fifo_level !== lv(1))
      $display("FAIL single_c2: tvalid=%0b tdata=%h level=%0d want 1/%h/%0d",
               m_if.tvalid, m_if.tdata, fifo_level, d, lv(1));
    else n_pass++;
    tick();
    n_total++;
    if (m_if.tvalid !== 1'b0 || fifo_level !== lv(0))
      $display("FAIL single_c3: tvalid=%0b level=%0d want 0/%0d", m_if.tvalid, fifo_level, lv(0));
    else n_pass++;
  endtask

  task automatic test_fill();
    int k;
    int got;
    int errs;
    logic late_ready;
    k = 0;
    late_ready = 1'b0;
    m_if.tready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata = DW'(k);
      if (k == 16 && s_if.tready) late_ready = 1'b1;
      if (s_if.tready) k++;
      tick();
    end
    n_total++;
    if (k !== 16 || late_ready !== 1'b0)
      $display("FAIL fill_accepted: got %0d ready_after_full=%0b want 16/0", k, late_ready);
    else n_pass++;
    n_total++;
    if (s_if.tready !== 1'b0 || fifo_level !== lv(16) || m_if.tvalid !== 1'b1 || m_if.tdata !== DW'(0))
      $display("FAIL fill_state: tready=%0b level=%0d tvalid=%0b tdata=%h want 0/%0d/1/0",
               s_if.tready, fifo_level, m_if.tvalid, m_if.tdata, lv(16));
    else n_pass++;
    m_if.tready = 1'b1;
    s_if.tdata = DW'(16);
    tick();
    m_if.tready = 1'b0;
    n_total++;
    if (s_if.tready !== 1'b1 || fifo_level !== lv(15))
      $display("FAIL fill_ready_rise: tready=%0b level=%0d want 1/%0d", s_if.tready, fifo_level, lv(15));
    else n_pass++;
    tick();
    s_if.tvalid = 1'b0;
    n_total++;
    if (s_if.tready !== 1'b0 || fifo_level !== lv(16) || m_if.tdata !== DW'(1))
      $display("FAIL fill_refull: tready=%0b level=%0d tdata=%h want 0/%0d/1",
               s_if.tready, fifo_level, m_if.tdata, lv(16));
    else n_pass++;
    m_if.tready = 1'b1;
    got = 0;
    errs = 0;
    for (int i = 0; i < 40 && got < 16; i++) begin
      if (m_if.tvalid) begin
        if (m_if.tdata !== DW'(got + 1)) errs++;
        got++;
      end
      tick();
    end
    n_total++;
    if (got !== 16 || errs !== 0)
      $display("FAIL fill_drain: got %0d beats %0d bad want 16/0", got, errs);
    else n_pass++;
    m_if.tready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int sidx, ridx, errs, bubbles;
    sidx = 0; ridx = 0; errs = 0; bubbles = 0;
    m_if.tready = 1'b1;
    for (int c = 0; c < 1100 && ridx < 1000; c++) begin
      s_if.tvalid = (sidx < 1000);
      s_if.tdata = DW'(1000 + sidx);
      if (m_if.tvalid) begin
        if (m_if.tdata !== DW'(1000 + ridx)) errs++;
        ridx++;
      end else if (ridx > 0) begin
        bubbles++;
      end
      if (s_if.tvalid && s_if.tready) sidx++;
      tick();
    end
    s_if.tvalid = 1'b0;
    n_total++;
    if (ridx !== 1000 || errs !== 0)
      $display("FAIL stream_data: got %0d beats %0d bad want 1000/0", ridx, errs);
    else n_pass++;
    n_total++;
    if (bubbles > 1) $display("FAIL stream_bubbles: got %0d want <=1", bubbles);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int sidx, ridx, errs, unstable, full_ready, lverr;
    logic prev_stall;
    logic [DW-1:0] prev_data;
    sidx = 0; ridx = 0; errs = 0; unstable = 0; full_ready = 0; lverr = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    for (int c = 0; c < 60000 && ridx < 10000; c++) begin
      s_if.tvalid = (sidx < 10000) && ($urandom_range(0, 1) == 1);
      s_if.tdata = pat(sidx);
      m_if.tready = ($urandom_range(0, 1) == 1);
      if (s_if.tready && (sidx - ridx) == DEPTH) full_ready++;
      if (fifo_level !== lv(sidx - ridx)) lverr++;
      if (prev_stall && (!m_if.tvalid || m_if.tdata !== prev_data)) unstable++;
      if (m_if.tvalid && m_if.tready) begin
        if (m_if.tdata !== pat(ridx)) errs++;
        ridx++;
      end
      if (s_if.tvalid && s_if.tready) sidx++;
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_data = m_if.tdata;
      tick();
    end
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b0;
    n_total++;
    if (ridx !== 10000 || errs !== 0)
      $display("FAIL random_scoreboard: got %0d beats %0d bad want 10000/0", ridx, errs);
    else n_pass++;
    n_total++;
    if (unstable !== 0) $display("FAIL random_stall_stable: got %0d violations want 0", unstable);
    else n_pass++;
    n_total++;
    if (full_ready !== 0) $display("FAIL random_ready_full: got %0d violations want 0", full_ready);
    else n_pass++;
    n_total++;
    if (lverr !== 0) $display("FAIL random_level: got %0d mismatches want 0", lverr);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    int k;
    int seen;
    logic [DW-1:0] d;
    k = 0;
    m_if.tready = 1'b0;
    for (int i = 0; i < 20 && k < 7; i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata = DW'(8'h10 + k);
      if (s_if.tready) k++;
      tick();
    end
    s_if.tvalid = 1'b0;
    tick();
    n_total++;
    if (fifo_level !== lv(7) || m_if.tvalid !== 1'b1)
      $display("FAIL midrst_pre: level=%0d tvalid=%0b want %0d/1", fifo_level, m_if.tvalid, lv(7));
    else n_pass++;
    axis_rst = 1'b1;
    tick(); tick();
    axis_rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (m_if.tvalid) seen++;
    end
    n_total++;
    if (seen !== 0 || fifo_level !== lv(0) || s_if.tready !== 1'b1)
      $display("FAIL midrst_post: tvalid_cycles=%0d level=%0d tready=%0b want 0/%0d/1",
               seen, fifo_level, s_if.tready, lv(0));
    else n_pass++;
    s_if.tvalid = 1'b1;
    s_if.tdata = DW'(8'hAA);
    m_if.tready = 1'b1;
    tick();
    s_if.tvalid = 1'b0;
    d = '0;
    seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      if (m_if.tvalid) begin
        seen = 1;
        d = m_if.tdata;
      end else begin
        tick();
      end
    end
    n_total++;
    if (seen !== 1 || d !== DW'(8'hAA))
      $display("FAIL midrst_first_beat: seen=%0d tdata=%h want 1/aa", seen, d);
    else n_pass++;
  endtask

  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata = '0;
    m_if.tready = 1'b0;
    test_reset();
    test_single_beat();
    test_fill();
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/axis_fifo_sync.md
# axis_fifo_sync

Single-clock AXI-stream FIFO with a registered output stage. It is the same-clock counterpart of our clock-converter FIFO: it buffers and retimes streams inside one clock domain, for example in front of a consumer that stalls or behind a producer that bursts. It breaks every combinational path between the slave and master handshakes. Storage is an inferred register/distributed RAM ring, and all flags are derived from registered state only.

## Interface
Parameters:
- DATA_WIDTH, 72, tdata width in bits.
- FIFO_DEPTH, 16, total beat capacity; power of two, ≥ 2.
- LW (localparam), clog2(FIFO_DEPTH)+1, level width.

Ports:
- axis_clk  in  1  single clock; all logic on rising edge.
- axis_rst  in  1  synchronous, active-high reset.
- s_axis_tvalid  in  1  slave beat valid.
- s_axis_tready  out  1  slave ready; registered.
- s_axis_tdata  in  DATA_WIDTH  slave data.
- m_axis_tvalid  out  1  master beat valid; registered.
- m_axis_tready  in  1  master ready.
- m_axis_tdata  out  DATA_WIDTH  master data; registered.
- fifo_level  out  LW  beats held, 0..FIFO_DEPTH; registered (see Configuration).

## Operation
- Write: on s_axis_tvalid & s_axis_tready, the beat is stored at wr_ptr, and wr_ptr is incremented modulo FIFO_DEPTH.
- Read: on m_axis_tvalid & m_axis_tready, the head is retired, and rd_ptr is incremented modulo FIFO_DEPTH.
- The output register holds a copy of the head entry. The head entry keeps its RAM slot until it is consumed, so capacity is exactly FIFO_DEPTH.
- Output register load: at an edge where the output is empty, or is being consumed, and at least one stored beat that is not yet in the output register was written in an earlier cycle. That beat is loaded and m_axis_tvalid is set to 1. Otherwise, m_axis_tvalid is cleared on consume, or held.
- Pointers are LW bits wide, using an extra wrap bit:
  - full = (wr_ptr ^ rd_ptr) == {1'b1, 0…}
  - empty = wr_ptr == rd_ptr
- s_axis_tready is a register equal to ~full of the next state. It never depends combinationally on m_axis_tready. A read does not raise tready until the following cycle.
- Simultaneous write and read while full: the write is not possible because tready is 0. The read proceeds, and tready rises the next cycle.
- Simultaneous write and read while the level is 1: both happen. The new beat enters the output register one cycle later, which gives one bubble cycle.
- m_axis_tdata is stable whenever m_axis_tvalid = 1 and m_axis_tready = 0.
- Reset values:
  - s_axis_tready = 0 during reset, then 1 in the first cycle after reset deasserts.
  - m_axis_tvalid = 0.
  - m_axis_tdata = 0.
  - fifo_level = 0.
  - Pointers = 0.
  - RAM contents are not reset.
- Reset mid-operation discards all stored beats. No beat is presented after reset until a new write occurs.

## Timing
- Latency when empty: a slave handshake in cycle c gives m_axis_tvalid = 1 in cycle c+2.
- Throughput: one beat per cycle sustained whenever ≥ 2 beats are buffered and m_axis_tready = 1.
- Full-to-ready: a read handshake in cycle c gives s_axis_tready = 1 in cycle c+1.
- fifo_level updates at the edge ending the handshake cycle:
  - +1 for a write only.
  - −1 for a read only.
  - Unchanged for both or neither.

## Configuration
- AXIS_FIFO_SYNC_LEVEL_EN defined: a level counter is instantiated, and fifo_level reports the beat count as specified above.
- AXIS_FIFO_SYNC_LEVEL_EN undefined: the counter logic is omitted, and fifo_level is tied to 0. Full, empty and handshake behaviour are identical in both builds.

## Test plan
All scenarios use DATA_WIDTH = 72 and FIFO_DEPTH = 16.
- Reset release: hold axis_rst for 3 cycles, then deassert → s_axis_tready=0 during reset, 1 the cycle after; m_axis_tvalid=0; fifo_level=0.
- Single beat: write 0x0123456789ABCDEF01 in cycle c with m_axis_tready=1 → m_axis_tvalid=1 with that data in cycle c+2, 0 in c+3; level goes 0→1→0.
- Fill: m_axis_tready=0, offer 20 beats 0..19 → exactly 16 accepted (0..15), s_axis_tready=0 from the cycle after the 16th write, fifo_level=16; then one read → tready=1 one cycle later and beat 16 is accepted.
- Streaming: tvalid and tready both held at 1 for 1000 beats of an incrementing pattern → output matches the input in order with no loss or duplication; after the initial 2-cycle fill, at most one bubble.
- Random backpressure: random tvalid/tready at 50% for 10k beats → the scoreboard matches; tdata is stable while stalled; s_axis_tready is never asserted while fifo_level=16.
- Mid-stream reset: assert axis_rst with level=7 → after release level=0, m_axis_tvalid=0, and the next written beat 0xAA is the first beat out.
